// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave.
// The optional command check is enabled with the SPI_CMD_CHECK_EN macro.
package spi_pkg;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 4;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } state_e;

  function automatic logic is_shift_state(state_e s);
    return (s == StWrite) || (s == StReadAdd) || (s == StReadData);
  endfunction

  // True when the frame's command field is legal for the state that received it.
  function automatic logic cmd_match(state_e s, logic [1:0] cmd);
    logic ok;
    ok = 1'b0;
    case (s)
      StReadAdd:  ok = (cmd == RD_ADDR);
      StReadData: ok = (cmd == RD_DATA);
      StWrite:    ok = (cmd == WR_ADDR) || (cmd == WR_DATA);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Latches a read byte and shifts it out MSB-first on MISO over 8 clocks.
// MISO is 0 whenever no shift-out is in progress.
module spi_tx_serializer
  import spi_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] byte_i,
  input  logic              abort_i,
  output logic              miso_o
);

  logic [DATA_W-1:0] latch_q, latch_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              active_q, active_d;

  // Next-state: abort wins, then a fresh latch, then shifting the held byte.
  always_comb begin
    latch_d  = latch_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (abort_i) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (start_i) begin
      latch_d  = byte_i;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      latch_d = {latch_q[DATA_W-2:0], 1'b0};
      if (cnt_q == 3'd7) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      latch_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      latch_q  <= latch_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign miso_o = active_q & latch_q[DATA_W-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for a RAM: deserialises 10-bit frames and serialises read data.
// Define SPI_CMD_CHECK_EN to reject frames whose command field does not match the state.
module spi_slave
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               MOSI,
  input  logic               SS_n,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               MISO,
  output logic               cmd_err
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-2:0]   shift_q, shift_d;
  logic                 done_q, done_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_flag_q, rd_flag_d;
  logic                 rd_wait_q, rd_wait_d;

  logic [FRAME_W-1:0]   frame;
  logic                 shift_en;
  logic                 last_bit;
  logic                 cmd_ok;
  logic                 tx_start;

  assign frame    = {shift_q, MOSI};
  assign shift_en = is_shift_state(state_q) && !SS_n && !done_q;
  assign last_bit = shift_en && (bit_cnt_q == CNT_W'(FRAME_W - 1));
  // Read data is accepted only while waiting after a good READ_DATA frame.
  assign tx_start = rd_wait_q && tx_valid && !SS_n;

`ifdef SPI_CMD_CHECK_EN
  logic cmd_err_q, cmd_err_d;
  assign cmd_ok  = cmd_match(state_q, frame[FRAME_W-1 -: 2]);
  assign cmd_err = cmd_err_q;
`else
  assign cmd_ok  = 1'b1;
  assign cmd_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; SS_n high returns to idle from anywhere.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!SS_n) state_d = StChkCmd;
      end
      StChkCmd: begin
        if (SS_n)          state_d = StIdle;
        else if (!MOSI)    state_d = StWrite;
        else if (rd_flag_q) state_d = StReadData;
        else               state_d = StReadAdd;
      end
      StWrite, StReadAdd, StReadData: begin
        if (SS_n) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next-state: frame shifting, completion, read flag.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = done_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_flag_d  = rd_flag_q;
    rd_wait_d  = rd_wait_q;
`ifdef SPI_CMD_CHECK_EN
    cmd_err_d  = 1'b0;
`endif
    if (SS_n) begin
      // Abort or idle: drop any partial frame, flag untouched.
      bit_cnt_d = '0;
      shift_d   = '0;
      done_d    = 1'b0;
      rd_wait_d = 1'b0;
    end else begin
      if (shift_en) begin
        shift_d   = frame[FRAME_W-2:0];
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (last_bit) begin
          bit_cnt_d = '0;
          done_d    = 1'b1;
          if (cmd_ok) begin
            rx_data_d  = frame;
            rx_valid_d = 1'b1;
            if (state_q == StReadAdd) rd_flag_d = 1'b1;
            if (state_q == StReadData) begin
              rd_flag_d = 1'b0;
              rd_wait_d = 1'b1;
            end
          end
`ifdef SPI_CMD_CHECK_EN
          if (!cmd_ok) cmd_err_d = 1'b1;
`endif
        end
      end
      if (tx_start) rd_wait_d = 1'b0;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_flag_q  <= 1'b0;
      rd_wait_q  <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_flag_q  <= rd_flag_d;
      rd_wait_q  <= rd_wait_d;
    end
  end

`ifdef SPI_CMD_CHECK_EN
  // Command-mismatch pulse register.
  always_ff @(posedge clk) begin
    if (rst) cmd_err_q <= 1'b0;
    else     cmd_err_q <= cmd_err_d;
  end
`endif

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  spi_tx_serializer u_tx_serializer (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (tx_start),
    .byte_i  (tx_data),
    .abort_i (SS_n),
    .miso_o  (MISO)
  );

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: stimulus pushes expected frames, read bytes and
// command errors; a negedge monitor pops and compares whenever the DUT presents them.
module tb_spi_slave;

  logic       clk;
  logic       rst;
  logic       MOSI;
  logic       SS_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       MISO;
  logic       cmd_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [9:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  int         exp_err[$];

  logic [7:0] miso_byte;
  int         miso_win = 0;

  spi_slave dut (
    .clk      (clk),
    .rst      (rst),
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .MISO     (MISO),
    .cmd_err  (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT presentation against the queued expectations.
  always @(negedge clk) begin
    logic [9:0] e;
    int         t;
    if (mon_en) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) chk("rx_valid_unexpected", 32'(rx_valid), 32'd0);
        else begin
          e = exp_rx.pop_front();
          chk("rx_data", 32'(rx_data), 32'(e));
        end
      end
      if (cmd_err) begin
        if (exp_err.size() == 0) chk("cmd_err_unexpected", 32'(cmd_err), 32'd0);
        else begin
          t = exp_err.pop_front();
          chk("cmd_err", 32'(cmd_err), 32'(t));
        end
      end
      if (miso_win > 0) begin
        chk("miso_bit", 32'(MISO), 32'(miso_byte[miso_win-1]));
        miso_win--;
        if (rst || SS_n) miso_win = 0;
      end else begin
        chk("miso_idle", 32'(MISO), 32'd0);
      end
      if (tx_valid && !rst && exp_miso.size() > 0) begin
        miso_byte = exp_miso.pop_front();
        miso_win  = 8;
      end
    end
  end

  task automatic open_frame(input logic dir, input logic [9:0] f, input int nbits);
    @(posedge clk); #1; SS_n = 1'b0;
    @(posedge clk); #1; MOSI = dir;
    for (int i = 9; i >= 10 - nbits; i--) begin
      @(posedge clk); #1; MOSI = f[i];
    end
  endtask

  task automatic close_frame();
    @(posedge clk); #1; SS_n = 1'b1; MOSI = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic simple_frame(input logic dir, input logic [9:0] f);
    exp_rx.push_back(f);
    open_frame(dir, f, 10);
    close_frame();
  endtask

  // READ_DATA frame, then tx_valid one cycle after rx_valid, then 8 shift-out clocks.
  task automatic read_data_frame(input logic [9:0] f, input logic [7:0] b);
    exp_rx.push_back(f);
    open_frame(1'b1, f, 10);
    @(posedge clk); #1;
    exp_miso.push_back(b);
    tx_data = b; tx_valid = 1'b1;
    @(posedge clk); #1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (9) @(posedge clk);
    #1; SS_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; MOSI = 1'b0; SS_n = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 32'h000);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rx_data", 32'(rx_data), 32'h000);
    chk("post_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("post_rst_miso", 32'(MISO), 32'd0);
    mon_en = 1'b1;

    // Write frame 00_1010_0101; rx_data must hold afterwards.
    simple_frame(1'b0, 10'h0A5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rx_data_hold", 32'(rx_data), 32'h0A5);

    // Write frame, then stray tx_valid and surplus MOSI bits while SS_n stays low.
    exp_rx.push_back(10'h13C);
    open_frame(1'b0, 10'h13C, 10);
    @(posedge clk); #1;
    exp_miso.push_back(8'h00);
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(posedge clk); #1; tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1; MOSI = ~MOSI;
    end
    close_frame();

    // Read address then read data with byte C3.
    simple_frame(1'b1, 10'h203);
    read_data_frame(10'h3A7, 8'hC3);

    // Abort after 5 bits, then a normal write.
    open_frame(1'b0, 10'h3FF, 5);
    @(posedge clk); #1; SS_n = 1'b1; MOSI = 1'b0;
    @(posedge clk); #1;
    simple_frame(1'b0, 10'h0C6);

    // SS_n rises on the same clock as the 10th bit: frame discarded.
    open_frame(1'b0, 10'h1FF, 9);
    @(posedge clk); #1; MOSI = 1'b1; SS_n = 1'b1;
    @(posedge clk); #1; MOSI = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rx_data_after_abort", 32'(rx_data), 32'h0C6);
    simple_frame(1'b0, 10'h07E);

    // Reset during the 4th MISO bit of byte A5.
    simple_frame(1'b1, 10'h2E1);
    exp_rx.push_back(10'h3C5);
    open_frame(1'b1, 10'h3C5, 10);
    @(posedge clk); #1;
    exp_miso.push_back(8'hA5);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clk); #1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rx_data", 32'(rx_data), 32'h000);

    // Reset clears the read-address flag: next 1-frame is READ_ADD, then READ_DATA works.
    simple_frame(1'b1, 10'h2F0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    simple_frame(1'b1, 10'h211);
    read_data_frame(10'h300, 8'h5A);

    // READ_ADD frame carrying command 00.
`ifdef SPI_CMD_CHECK_EN
    exp_err.push_back(1);
    open_frame(1'b1, 10'h055, 10);
    close_frame();
`else
    simple_frame(1'b1, 10'h055);
`endif

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    chk("miso_queue_drained", 32'(exp_miso.size()), 32'd0);
    chk("err_queue_drained", 32'(exp_err.size()), 32'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
